// File: rtl/wb_mem_master.sv
// Wishbone B4 pipelined master: runs one load/store bus cycle per accepted command,
// with byte-lane steering, load extension and misalign/error/timeout reporting.
module wb_mem_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic            i_cmd_we,
  input  logic [DW-1:0]   i_cmd_wdata,
  input  logic [1:0]      i_cmd_width,
  input  logic            i_cmd_signed,
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_data,
  output logic [1:0]      o_rsp_code,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic            i_wb_stall
);

  localparam int unsigned SelW = DW / 8;
  localparam int unsigned OffW = $clog2(SelW);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [AW-1:0]       wb_addr_q, wb_addr_d;
  logic [DW-1:0]       wb_data_q, wb_data_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [OffW-1:0]     off_q, off_d;
  logic [1:0]          width_q, width_d;
  logic                sgn_q, sgn_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_code_q, rsp_code_d;
  logic [31:0]         cnt_q, cnt_d;

  logic [OffW-1:0]     cmd_off;
  logic [7:0]          sel_base;
  logic [2:0]          align;
  logic                cmd_illegal;
  logic [DW-1:0]       shifted, mask, raw, top_bit, load_data;
  logic                bus_done, timeout_hit;

  assign cmd_off = i_cmd_addr[OffW-1:0];

  always_comb begin
    sel_base = 8'hff;
    align    = 3'd7;
    unique case (i_cmd_width)
      2'd0:    begin sel_base = 8'h01; align = 3'd0; end
      2'd1:    begin sel_base = 8'h03; align = 3'd1; end
      2'd2:    begin sel_base = 8'h0f; align = 3'd3; end
      default: begin sel_base = 8'hff; align = 3'd7; end
    endcase
    cmd_illegal = (|(cmd_off & align[OffW-1:0])) || ((i_cmd_width == 2'd3) && (DW != 64));
  end

  // Load path: shift the addressed lane down, mask to size, extend from its top bit.
  always_comb begin
    shifted = i_wb_data >> {off_q, 3'b000};
    mask    = '1;
    unique case (width_q)
      2'd0:    mask = DW'(8'hff);
      2'd1:    mask = DW'(16'hffff);
      2'd2:    mask = DW'(32'hffff_ffff);
      default: mask = '1;
    endcase
    raw       = shifted & mask;
    top_bit   = mask & ~(mask >> 1);
    load_data = (sgn_q && |(shifted & top_bit)) ? (raw | ~mask) : raw;
  end

  assign bus_done    = ((state_q == StReq && !i_wb_stall) || state_q == StWait) &&
                       (i_wb_ack || i_wb_err);
  assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    sel_d       = sel_q;
    off_d       = off_q;
    width_d     = width_q;
    sgn_d       = sgn_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_code_d  = rsp_code_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          off_d   = cmd_off;
          width_d = i_cmd_width;
          sgn_d   = i_cmd_signed;
          we_d    = i_cmd_we;
          if (cmd_illegal) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_code_d  = 2'b11;
            rsp_data_d  = '0;
          end else begin
            state_d   = StReq;
            cyc_d     = 1'b1;
            stb_d     = 1'b1;
            cnt_d     = '0;
            wb_addr_d = {i_cmd_addr[AW-1:OffW], {OffW{1'b0}}};
            wb_data_d = i_cmd_wdata << {cmd_off, 3'b000};
            sel_d     = SelW'(sel_base) << cmd_off;
          end
        end
      end
      StReq, StWait: begin
        cnt_d = cnt_q + 32'd1;
        if (bus_done) begin
          state_d     = StResp;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = i_wb_err ? 2'b01 : 2'b00;
          rsp_data_d  = (i_wb_err || we_q) ? '0 : load_data;
        end else if (timeout_hit) begin
          state_d     = StResp;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = 2'b10;
          rsp_data_d  = '0;
        end else if (state_q == StReq && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = StWait;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      sel_q       <= '0;
      off_q       <= '0;
      width_q     <= '0;
      sgn_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_code_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      sel_q       <= sel_d;
      off_q       <= off_d;
      width_q     <= width_d;
      sgn_q       <= sgn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_code_q  <= rsp_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_cmd_ready = (state_q == StIdle);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_code  = rsp_code_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = wb_addr_q;
  assign o_wb_data   = wb_data_q;
  assign o_wb_sel    = sel_q;

endmodule

// File: tb/tb_wb_mem_master.sv
// Directed bench for wb_mem_master (DW=32, TIMEOUT=4) with a transaction-level model
// and a per-cycle compare process.
module tb_wb_mem_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [31:0] i_cmd_addr;
  logic        i_cmd_we;
  logic [31:0] i_cmd_wdata;
  logic [1:0]  i_cmd_width;
  logic        i_cmd_signed;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_code;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_data;
  logic        i_wb_ack, i_wb_err, i_wb_stall;

  wb_mem_master #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_we     (i_cmd_we),
    .i_cmd_wdata  (i_cmd_wdata),
    .i_cmd_width  (i_cmd_width),
    .i_cmd_signed (i_cmd_signed),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_code   (o_rsp_code),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_data    (i_wb_data),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err),
    .i_wb_stall   (i_wb_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Expected transaction outcome, filled by the model before each command.
  bit          mon_en = 1'b0;
  int          k = 0;
  bit          e_legal, e_we;
  int          e_done, e_stb_n;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [1:0]  e_code;

  // Captured DUT values for the hand-computed literal checks.
  int          cap_cyc_n, cap_stb_n, cap_rsp_n;
  logic [3:0]  cap_sel;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic        cap_we;
  logic [1:0]  cap_code;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cyc", o_wb_cyc, e_legal && k <= e_done);
      chk("stb", o_wb_stb, e_legal && k <= e_stb_n);
      chk("rsp_valid", o_rsp_valid, k == e_done + 1);
      chk("cmd_ready", o_cmd_ready, k > e_done + 1);
      if (o_wb_cyc) begin
        cap_cyc_n++;
        cap_sel = o_wb_sel; cap_addr = o_wb_addr; cap_wdata = o_wb_data; cap_we = o_wb_we;
        chk("wb_addr", o_wb_addr, e_addr);
        chk("wb_sel", o_wb_sel, e_sel);
        chk("wb_we", o_wb_we, e_we);
        chk("wb_data", o_wb_data, e_wdata);
      end
      if (o_wb_stb) cap_stb_n++;
      if (o_rsp_valid) begin
        cap_rsp_n++;
        cap_rdata = o_rsp_data; cap_code = o_rsp_code;
      end
      if (k >= e_done + 1) begin
        chk("rsp_data", o_rsp_data, e_rdata);
        chk("rsp_code", o_rsp_code, e_code);
      end
    end
  end

  task automatic model(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                       input logic [1:0] width, input bit sgn, input int stall_n,
                       input int rsp_cyc, input bit errf, input logic [31:0] rdata);
    int size, off;
    logic [63:0] msk, raw;
    size    = 1 << width;
    off     = addr % 4;
    e_legal = (width != 2'd3) && (off % size == 0);
    e_sel   = 4'(((1 << size) - 1) << off);
    e_addr  = addr & ~32'h3;
    e_wdata = 32'(64'(wdata) << (8 * off));
    e_we    = we;
    msk     = (64'd1 << (8 * size)) - 64'd1;
    raw     = (64'(rdata) >> (8 * off)) & msk;
    if (sgn && raw[8 * size - 1]) raw = raw | ~msk;
    if (!e_legal) begin
      e_done = 0; e_code = 2'b11; e_rdata = 0;
    end else if (rsp_cyc != 0 && rsp_cyc <= TO) begin
      e_done  = rsp_cyc;
      e_code  = errf ? 2'b01 : 2'b00;
      e_rdata = (errf || we) ? 32'h0 : raw[31:0];
    end else begin
      e_done = TO; e_code = 2'b10; e_rdata = 0;
    end
    e_stb_n = !e_legal ? 0 : ((stall_n + 1 < e_done) ? stall_n + 1 : e_done);
  endtask

  task automatic run_txn(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                         input logic [1:0] width, input bit sgn, input int stall_n,
                         input int rsp_cyc, input bit ackf, input bit errf,
                         input logic [31:0] rdata, input int late_cyc);
    model(addr, we, wdata, width, sgn, stall_n, rsp_cyc, errf, rdata);
    cap_cyc_n = 0; cap_stb_n = 0; cap_rsp_n = 0;
    chk("ready_before_cmd", o_cmd_ready, 1'b1);
    i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_we = we; i_cmd_wdata = wdata;
    i_cmd_width = width; i_cmd_signed = sgn;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    mon_en = 1'b1;
    for (int c = 1; c <= e_done + 3; c++) begin
      k          = c;
      i_wb_stall = (c <= stall_n);
      i_wb_ack   = ((c == rsp_cyc) && ackf) || (c == late_cyc);
      i_wb_err   = (c == rsp_cyc) && errf;
      i_wb_data  = rdata;
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_addr = 0; i_cmd_we = 0; i_cmd_wdata = 0;
    i_cmd_width = 0; i_cmd_signed = 0;
    i_wb_data = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", o_wb_cyc, 1'b0);
    chk("rst_stb", o_wb_stb, 1'b0);
    chk("rst_we", o_wb_we, 1'b0);
    chk("rst_addr", o_wb_addr, 32'h0);
    chk("rst_wdata", o_wb_data, 32'h0);
    chk("rst_sel", o_wb_sel, 4'h0);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rsp_data", o_rsp_data, 32'h0);
    chk("rst_rsp_code", o_rsp_code, 2'b00);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", o_cmd_ready, 1'b1);

    // Signed byte load from the top lane.
    run_txn(32'h1003, 0, 32'h0, 2'd0, 1, 0, 2, 1, 0, 32'h80FF_FF12, 0);
    chk("t1_sel", cap_sel, 4'b1000);
    chk("t1_addr", cap_addr, 32'h1000);
    chk("t1_rdata", cap_rdata, 32'hFFFF_FF80);
    chk("t1_code", cap_code, 2'b00);
    chk("t1_rsp_n", cap_rsp_n, 1);

    // Half store to the upper lane.
    run_txn(32'h2002, 1, 32'h0000_BEEF, 2'd1, 0, 0, 2, 1, 0, 32'h1234_5678, 0);
    chk("t2_sel", cap_sel, 4'b1100);
    chk("t2_wdata", cap_wdata, 32'hBEEF_0000);
    chk("t2_we", cap_we, 1'b1);
    chk("t2_rdata", cap_rdata, 32'h0);
    chk("t2_code", cap_code, 2'b00);

    // Misaligned word load: no bus cycle.
    run_txn(32'h3002, 0, 32'h0, 2'd2, 0, 0, 2, 1, 0, 32'hAAAA_AAAA, 0);
    chk("t3_cyc_n", cap_cyc_n, 0);
    chk("t3_code", cap_code, 2'b11);
    chk("t3_rsp_n", cap_rsp_n, 1);

    // Three stall cycles, ack when stall drops.
    run_txn(32'h4000, 0, 32'h0, 2'd2, 0, 3, 4, 1, 0, 32'hCAFE_F00D, 0);
    chk("t4_stb_n", cap_stb_n, 4);
    chk("t4_rsp_n", cap_rsp_n, 1);
    chk("t4_rdata", cap_rdata, 32'hCAFE_F00D);
    chk("t4_code", cap_code, 2'b00);

    // Silent slave: timeout, then a late ack while idle.
    run_txn(32'h4100, 0, 32'h0, 2'd2, 0, 0, 0, 0, 0, 32'h5555_5555, 7);
    chk("t5_cyc_n", cap_cyc_n, 4);
    chk("t5_code", cap_code, 2'b10);
    chk("t5_rsp_n", cap_rsp_n, 1);

    // ack and err together: err wins.
    run_txn(32'h4200, 0, 32'h0, 2'd2, 0, 0, 2, 1, 1, 32'h1234_5678, 0);
    chk("t6_code", cap_code, 2'b01);
    chk("t6_rdata", cap_rdata, 32'h0);

    // Further lane/extension patterns.
    run_txn(32'h5002, 0, 32'h0, 2'd1, 1, 0, 2, 1, 0, 32'h8001_1234, 0);
    chk("t7_rdata", cap_rdata, 32'hFFFF_8001);
    run_txn(32'h5000, 0, 32'h0, 2'd1, 0, 0, 2, 1, 0, 32'h1234_F00F, 0);
    chk("t8_rdata", cap_rdata, 32'h0000_F00F);
    run_txn(32'h6001, 0, 32'h0, 2'd0, 0, 0, 1, 1, 0, 32'h0000_80AA, 0);
    chk("t9_rdata", cap_rdata, 32'h0000_0080);
    chk("t9_sel", cap_sel, 4'b0010);
    run_txn(32'h7000, 1, 32'hDEAD_BEEF, 2'd2, 0, 1, 3, 1, 0, 32'h0, 0);
    chk("t10_sel", cap_sel, 4'b1111);
    chk("t10_wdata", cap_wdata, 32'hDEAD_BEEF);
    run_txn(32'h7000, 0, 32'h0, 2'd3, 0, 0, 2, 1, 0, 32'h0, 0);
    chk("t11_code", cap_code, 2'b11);
    run_txn(32'h1001, 0, 32'h0, 2'd1, 0, 0, 2, 1, 0, 32'h0, 0);
    chk("t12_code", cap_code, 2'b11);

    // Reset while waiting for ack.
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h8000; i_cmd_we = 0; i_cmd_width = 2'd2;
    i_cmd_signed = 0;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t13_cyc_wait", o_wb_cyc, 1'b1);
    chk("t13_stb_wait", o_wb_stb, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t13_cyc_still", o_wb_cyc, 1'b1);
    @(posedge clk); #1;
    chk("t13_cyc_rst", o_wb_cyc, 1'b0);
    chk("t13_stb_rst", o_wb_stb, 1'b0);
    chk("t13_rsp_rst", o_rsp_valid, 1'b0);
    reset = 1'b1;
    i_wb_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t13_no_rsp", o_rsp_valid, 1'b0);
      chk("t13_ready", o_cmd_ready, 1'b1);
      chk("t13_no_cyc", o_wb_cyc, 1'b0);
    end
    i_wb_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
